shift_normalizer: RTL and testbench
===================================

Name: shift_normalizer

Overview:
- Multi-cycle normalizer for the ALU datapath. It is the inverse of the combinational barrel shifter: given an operand, it finds the shift count that normalizes it.
- Left mode counts leading zeros and produces the value shifted left until bit 15 is 1. Right mode counts trailing zeros and produces the value shifted right until bit 0 is 1.
- Feeding Out and Cnt back through the barrel shifter with the opposite logical shift reproduces In. It serves the pipeline as a start/done coprocessor for normalize/count-zeros instructions.

Parameters:
- WIDTH, 16, operand width (only 16 supported).
- CNT_W, 4, shift-count width, log2(WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- In  input  16  operand; captured on the accepted start edge.
- Dir  input  1  0 = normalize left (count leading zeros); 1 = normalize right (count trailing zeros). Captured with In.
- Out  output  16  normalized result.
- Cnt  output  4  number of single-bit shifts applied.
- zero  output  1  captured operand was 0x0000.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: rst_n low asynchronously forces state=IDLE and clears the shift register, the count register and the zero/done flags. Reset applies mid-operation and discards the operation with no done pulse. Reset values: Out=0x0000, Cnt=0, zero=0, busy=0, done=0.
- States:
  - IDLE: busy=0, done=0. On a clock edge with start=1, capture In into sreg and Dir into dir_q, and set cnt=0. If In==0x0000, go to DONE with zero=1. Otherwise set zero=0 and go to SHIFT.
  - SHIFT: busy=1. On each edge, test the target bit (sreg[15] when dir_q=0, sreg[0] when dir_q=1).
    - Target bit set: go to DONE; sreg and cnt hold.
    - Target bit clear: shift sreg by 1 toward the target with zero fill (left: {sreg[14:0],0}; right: {0,sreg[15:1]}) and increment cnt.
  - DONE: busy=1, done=1 for exactly one cycle, then IDLE unconditionally.
- Start handling: start is ignored in SHIFT and DONE; it is neither queued nor allowed to alter the captured operands. A start present during the DONE cycle is also dropped; the requester re-asserts it in IDLE.
- Outputs: Out=sreg and Cnt=cnt, both registered and driven continuously. They hold their final values after DONE until the next accepted start, then track the intermediate shift values during SHIFT. zero holds until the next accepted start.
- Latency: with k = leading zeros (left) or trailing zeros (right), k in 0..15, start accepted at edge E0:
  - done is high during the cycle after edge E0+k+1.
  - Zero operand: done is high during the cycle after E0, with Cnt=0 and Out=0.
  - Worst case non-zero: 17 cycles from start to done.
- Count range: Cnt never exceeds 15, so no wrap is possible; a non-zero operand always terminates by cnt=15.
- Width rules: shifts are logical only; bits shifted out are discarded. Since only zeros are shifted out before the target bit is reached, no information is lost.
- Consistency invariants:
  - Left mode, non-zero: (Out >> Cnt) == In and Out[15]==1.
  - Right mode, non-zero: (Out << Cnt) == In and Out[0]==1.

Test Plan:
- In=0x0001, Dir=0, start pulse -> Out=0x8000, Cnt=15, zero=0; done in the cycle after E0+16; busy high for 17 cycles.
- In=0x8000, Dir=0 -> Out=0x8000, Cnt=0; done in the cycle after E0+1.
- In=0x00F0, Dir=1 -> Out=0x000F, Cnt=4; also In=0x0C00, Dir=0 -> Out=0xC000, Cnt=4. Check each result through the barrel shifter (SLL/SRL by Cnt) reproduces In.
- In=0x0000 in both directions -> zero=1, Out=0x0000, Cnt=0; done in the cycle after E0.
- Start In=0x0010, Dir=0, then re-assert start with In=0xFFFF during SHIFT and during DONE -> both ignored; result Out=0x8000, Cnt=11; exactly one done pulse.
- Start In=0x0001, Dir=0, drop rst_n at cycle 5 -> outputs clear immediately, no done pulse. A start after rst_n rises with In=0x4000 -> Out=0x8000, Cnt=1.

Source files
------------

// File: rtl/shift_normalizer.sv
// Multi-cycle normalizer: shifts an operand one bit per cycle until the
// target end bit (MSB for left, LSB for right) is set, counting the shifts.
module shift_normalizer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] In,
  input  logic             Dir,
  output logic [WIDTH-1:0] Out,
  output logic [CNT_W-1:0] Cnt,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             zero_q, zero_d;
  logic             targetBit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      zero_q  <= zero_d;
    end
  end

  assign targetBit = dir_q ? sreg_q[0] : sreg_q[WIDTH-1];

  // A non-zero operand always reaches its target bit within WIDTH-1 shifts,
  // so the counter cannot wrap.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sreg_d = In;
          dir_d  = Dir;
          cnt_d  = '0;
          if (In == '0) begin
            zero_d  = 1'b1;
            state_d = DONE;
          end else begin
            zero_d  = 1'b0;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (targetBit) begin
          state_d = DONE;
        end else begin
          sreg_d = dir_q ? {1'b0, sreg_q[WIDTH-1:1]} : {sreg_q[WIDTH-2:0], 1'b0};
          cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Out  = sreg_q;
  assign Cnt  = cnt_q;
  assign zero = zero_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_shift_normalizer.sv
// Scoreboard bench for shift_normalizer: directed operands with hand-computed
// results; a monitor checks every done pulse against the expected queue.
module tb_shift_normalizer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] In;
  logic        Dir;
  logic [15:0] Out;
  logic [3:0]  Cnt;
  logic        zero;
  logic        busy;
  logic        done;

  typedef struct {
    logic [15:0] inVal;
    logic        dir;
    logic [15:0] expOut;
    logic [3:0]  expCnt;
    logic        expZero;
    int          doneCyc;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  shift_normalizer #(.WIDTH(16), .CNT_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .In   (In),
    .Dir  (Dir),
    .Out  (Out),
    .Cnt  (Cnt),
    .zero (zero),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        logic [15:0] recon;
        e = expQ.pop_front();
        checkOutput("out", Out, e.expOut);
        checkOutput("cnt", Cnt, e.expCnt);
        checkOutput("zero", zero, e.expZero);
        checkOutput("done_cycle", cyc, e.doneCyc);
        if (!e.expZero) begin
          recon = e.dir ? (Out << Cnt) : (Out >> Cnt);
          checkOutput("reconstruct", recon, e.inVal);
          checkOutput("target_bit", e.dir ? Out[0] : Out[15], 1);
        end
      end
    end
  end

  task automatic waitDone(output int busyCnt, output bit ok);
    busyCnt = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busyCnt++;
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic issue(input logic [15:0] inVal, input logic dir,
                       input logic [15:0] expOut, input logic [3:0] expCnt,
                       input logic expZero);
    exp_t e;
    @(negedge clk);
    In    = inVal;
    Dir   = dir;
    start = 1'b1;
    e.inVal   = inVal;
    e.dir     = dir;
    e.expOut  = expOut;
    e.expCnt  = expCnt;
    e.expZero = expZero;
    e.doneCyc = (cyc + 1) + (expZero ? 0 : int'(expCnt) + 1);
    expQ.push_back(e);
    @(negedge clk);
    start = 1'b0;
    In    = 16'h0000;
  endtask

  task automatic applyStimulus(input logic [15:0] inVal, input logic dir,
                               input logic [15:0] expOut, input logic [3:0] expCnt,
                               input logic expZero);
    int busyCnt;
    bit ok;
    issue(inVal, dir, expOut, expCnt, expZero);
    waitDone(busyCnt, ok);
    checkOutput("done_seen", ok, 1);
    checkOutput("busy_cycles", busyCnt, expZero ? 1 : int'(expCnt) + 2);
    @(negedge clk);
    checkOutput("busy_after_done", busy, 0);
    checkOutput("zero_hold", zero, expZero);
  endtask

  initial begin
    int busyCnt;
    bit ok;
    rst_n = 1'b0;
    start = 1'b0;
    In    = 16'h0000;
    Dir   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_out", Out, 16'h0000);
    checkOutput("reset_cnt", Cnt, 0);
    checkOutput("reset_zero", zero, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(16'h0001, 1'b0, 16'h8000, 4'd15, 1'b0);
    applyStimulus(16'h8000, 1'b0, 16'h8000, 4'd0,  1'b0);
    applyStimulus(16'h00F0, 1'b1, 16'h000F, 4'd4,  1'b0);
    applyStimulus(16'h0C00, 1'b0, 16'hC000, 4'd4,  1'b0);
    applyStimulus(16'h0000, 1'b0, 16'h0000, 4'd0,  1'b1);
    applyStimulus(16'h0000, 1'b1, 16'h0000, 4'd0,  1'b1);
    applyStimulus(16'h8000, 1'b1, 16'h0001, 4'd15, 1'b0);
    applyStimulus(16'h0001, 1'b1, 16'h0001, 4'd0,  1'b0);
    applyStimulus(16'h0A50, 1'b1, 16'h00A5, 4'd4,  1'b0);

    // Starts during SHIFT and during DONE must be dropped.
    issue(16'h0010, 1'b0, 16'h8000, 4'd11, 1'b0);
    repeat (3) @(negedge clk);
    In = 16'hFFFF; Dir = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; In = 16'h0000; Dir = 1'b0;
    waitDone(busyCnt, ok);
    checkOutput("ign_done_seen", ok, 1);
    In = 16'hFFFF; Dir = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; In = 16'h0000; Dir = 1'b0;
    checkOutput("ign_busy_after", busy, 0);
    repeat (20) @(negedge clk);
    checkOutput("ign_out_hold", Out, 16'h8000);
    checkOutput("ign_cnt_hold", Cnt, 11);

    // Mid-operation reset discards the operation without a done pulse.
    @(negedge clk);
    In = 16'h0001; Dir = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; In = 16'h0000;
    repeat (4) @(negedge clk);
    checkOutput("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_out", Out, 16'h0000);
    checkOutput("rst_mid_cnt", Cnt, 0);
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("rst_no_done_busy", busy, 0);
    applyStimulus(16'h4000, 1'b0, 16'h8000, 4'd1, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("queue_empty", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
